// File: rtl/flt_fix_pkg.sv
// Shared types and constants for the float16 -> int16 sequential converter.
// Holds the FSM state encoding and the float16 field constants used by the
// classifier and the top-level datapath.
package flt_fix_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_SHIFT,
    S_FIX_SIGN,
    S_WR_LO,
    S_WR_HI
  } state_t;

  // float16 exponent bias and all-ones exponent (inf/NaN)
  localparam logic [4:0]  F16_BIAS    = 5'd15;
  localparam logic [4:0]  F16_EXP_MAX = 5'd31;

  // Exponent at which the 11-bit mantissa {1,frac} is already an integer
  localparam logic [4:0]  E_UNITY     = 5'd25;

  // First exponent whose magnitude no longer fits in int16 (>= 2^15)
  localparam logic [4:0]  E_SAT_MIN   = F16_EXP_MAX - 5'd1;

  localparam logic [15:0] SAT_POS     = 16'h7FFF;
  localparam logic [15:0] SAT_NEG     = 16'h8000;

endpackage

// File: rtl/f16_classify.sv
// Combinational float16 field decode and range classification.
// Ports: hi/lo = float16 bytes in; sgn/e/m = fields with hidden bit restored;
//        is_zero_out/is_sat = range class; shift_dir (1=left) and n = shift plan.
module f16_classify
  import flt_fix_pkg::*;
(
  input  logic [7:0]  hi,
  input  logic [7:0]  lo,
  output logic        sgn,
  output logic [4:0]  e,
  output logic [10:0] m,
  output logic        is_zero_out,
  output logic        is_sat,
  output logic        shift_dir,
  output logic [3:0]  n
);

  always_comb begin
    sgn         = hi[7];
    e           = hi[6:2];
    m           = {1'b1, hi[1:0], lo};
    is_zero_out = 1'b0;
    is_sat      = 1'b0;
    shift_dir   = 1'b0;
    n           = 4'd0;

    if (e < F16_BIAS) begin
      // |x| < 1 (including zero and subnormals) truncates to zero
      is_zero_out = 1'b1;
    end else if (e >= E_SAT_MIN) begin
      // |x| >= 32768, inf and NaN all clamp; -32768 exactly also lands here
      is_sat = 1'b1;
    end else if (e <= E_UNITY) begin
      shift_dir = 1'b0;
      n         = 4'(E_UNITY - e);
    end else begin
      // e in 26..29: at most 4 left shifts, so bit 15 is never reached
      shift_dir = 1'b1;
      n         = 4'(e - E_UNITY);
    end
  end

endmodule

// File: rtl/flt16_to_fix16_seq.sv
// Sequential float16 -> int16 converter sharing one 8-bit data memory port.
// Ports: clk/reset (sync, active-high); start/done handshake; DataAddress,
//        ReadMem, WriteMem, DataIn, DataOut form the data_mem interface.
// Latency: done rises on the (6+n)th edge after start is sampled, n in 0..10.
module flt16_to_fix16_seq
  import flt_fix_pkg::*;
#(
  parameter logic [7:0] SRC_ADDR = 8'd2,
  parameter logic [7:0] DST_ADDR = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] DataAddress,
  output logic       ReadMem,
  output logic       WriteMem,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut
);

  state_t state;
  state_t next_state;

  logic [7:0]  lo_q;
  logic        sgn_q;
  logic        sat_q;
  logic        dir_q;
  logic [3:0]  cnt_q;
  logic [15:0] mag_q;
  logic [15:0] result_q;

  logic        cls_sgn;
  logic [10:0] cls_m;
  logic        cls_is_zero;
  logic        cls_is_sat;
  logic        cls_dir;
  logic [3:0]  cls_n;
  // The exponent is fully consumed inside the classifier; it stays on the
  // port list so the decode can be probed, but nothing here needs it.
  logic [4:0]  cls_e_unused;

  // The hi byte is classified straight off the memory bus during RD_HI,
  // so only the lo byte needs a holding register.
  f16_classify u_classify (
    .hi          (DataOut),
    .lo          (lo_q),
    .sgn         (cls_sgn),
    .e           (cls_e_unused),
    .m           (cls_m),
    .is_zero_out (cls_is_zero),
    .is_sat      (cls_is_sat),
    .shift_dir   (cls_dir),
    .n           (cls_n)
  );

  assign ReadMem = 1'b1;

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:     if (start) next_state = S_RD_LO;
      S_RD_LO:    next_state = S_RD_HI;
      S_RD_HI:    next_state = S_SHIFT;
      // SHIFT always spends one cycle checking the count, hence n+1 cycles
      S_SHIFT:    if (cnt_q == 4'd0) next_state = S_FIX_SIGN;
      S_FIX_SIGN: next_state = S_WR_LO;
      S_WR_LO:    next_state = S_WR_HI;
      S_WR_HI:    next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Memory port outputs
  always_comb begin
    DataAddress = 8'd0;
    WriteMem    = 1'b0;
    DataIn      = 8'd0;
    unique case (state)
      S_RD_LO: DataAddress = SRC_ADDR;
      S_RD_HI: DataAddress = SRC_ADDR + 8'd1;
      S_WR_LO: begin
        DataAddress = DST_ADDR;
        WriteMem    = 1'b1;
        DataIn      = result_q[7:0];
      end
      S_WR_HI: begin
        DataAddress = DST_ADDR + 8'd1;
        WriteMem    = 1'b1;
        DataIn      = result_q[15:8];
      end
      default: ;
    endcase
    // Reset must suppress a write on the very edge it is sampled, not only
    // after the state register has been cleared.
    if (reset) begin
      DataAddress = 8'd0;
      WriteMem    = 1'b0;
      DataIn      = 8'd0;
    end
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      lo_q     <= 8'd0;
      sgn_q    <= 1'b0;
      sat_q    <= 1'b0;
      dir_q    <= 1'b0;
      cnt_q    <= 4'd0;
      mag_q    <= 16'd0;
      result_q <= 16'd0;
    end else begin
      state <= next_state;
      unique case (state)
        S_IDLE: begin
          if (start) done <= 1'b0;
        end
        S_RD_LO: begin
          lo_q <= DataOut;
        end
        S_RD_HI: begin
          sgn_q <= cls_sgn;
          sat_q <= cls_is_sat;
          dir_q <= cls_dir;
          cnt_q <= cls_n;
          mag_q <= (cls_is_zero || cls_is_sat) ? 16'd0 : {5'd0, cls_m};
        end
        S_SHIFT: begin
          if (cnt_q != 4'd0) begin
            // Right shifts drop bits, which is truncation toward zero
            // because the sign is applied afterwards to the magnitude.
            mag_q <= dir_q ? (mag_q << 1) : (mag_q >> 1);
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_FIX_SIGN: begin
          if (sat_q) begin
            result_q <= sgn_q ? SAT_NEG : SAT_POS;
          end else begin
            // A zero magnitude negates to zero, so -0 and -0.5 give 0000
            result_q <= sgn_q ? (16'd0 - mag_q) : mag_q;
          end
        end
        S_WR_HI: begin
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flt16_to_fix16_seq.sv
// Self-checking bench for flt16_to_fix16_seq with a behavioural data memory.
// Ports driven: clk, reset, start; memory model answers DataOut and captures writes.
// Vectors carry the float, expected int16 and expected done-edge count.
module tb_flt16_to_fix16_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] data_address;
  logic       read_mem;
  logic       write_mem;
  logic [7:0] data_in;
  logic [7:0] data_out;

  logic [7:0] mem [256];
  int         wr_count;
  int         checks;
  int         errors;

  always #5 clk = ~clk;

  flt16_to_fix16_seq #(.SRC_ADDR(8'd2), .DST_ADDR(8'd4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .DataAddress (data_address),
    .ReadMem     (read_mem),
    .WriteMem    (write_mem),
    .DataIn      (data_in),
    .DataOut     (data_out)
  );

  assign data_out = mem[data_address];

  always @(posedge clk) begin
    if (write_mem) begin
      mem[data_address] = data_in;
      wr_count = wr_count + 1;
    end
  end

  typedef struct {
    logic [15:0] f;
    logic [15:0] exp_val;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] val;
    int          lat;
  } exp_t;

  vec_t vecs [17];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic load_float(input logic [15:0] f);
    mem[2] = f[7:0];
    mem[3] = f[15:8];
    mem[4] = 8'hA5;
    mem[5] = 8'h5A;
  endtask

  task automatic convert(input logic [15:0] f, input logic [15:0] ev, input int el);
    exp_t e;
    int   lat;
    @(negedge clk);
    load_float(f);
    wr_count = 0;
    start    = 1'b1;
    sb.push_back('{val: ev, lat: el});
    @(posedge clk);
    #1 start = 1'b0;
    chk($sformatf("done_clear_%h", f), {31'd0, done}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    chk($sformatf("latency_%h", f), lat, e.lat);
    chk($sformatf("result_%h", f), {16'd0, mem[5], mem[4]}, {16'd0, e.val});
    chk($sformatf("writes_%h", f), wr_count, 32'd2);
    repeat (2) @(posedge clk);
    #1 chk($sformatf("done_hold_%h", f), {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int rises;
    int rise_edge;
    logic done_prev;

    checks   = 0;
    errors   = 0;
    wr_count = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0]  = '{16'h3C00, 16'h0001, 16};
    vecs[1]  = '{16'hC100, 16'hFFFE, 15};
    vecs[2]  = '{16'h6400, 16'h0400, 6};
    vecs[3]  = '{16'h7BFF, 16'h7FFF, 6};
    vecs[4]  = '{16'hFBFF, 16'h8000, 6};
    vecs[5]  = '{16'hF800, 16'h8000, 6};
    vecs[6]  = '{16'h7C00, 16'h7FFF, 6};
    vecs[7]  = '{16'h7E00, 16'h7FFF, 6};
    vecs[8]  = '{16'h3800, 16'h0000, 6};
    vecs[9]  = '{16'hB800, 16'h0000, 6};
    vecs[10] = '{16'h0001, 16'h0000, 6};
    vecs[11] = '{16'h8000, 16'h0000, 6};
    vecs[12] = '{16'h5000, 16'h0020, 11};
    vecs[13] = '{16'hD3FF, 16'hFFC1, 11};
    vecs[14] = '{16'h7400, 16'h4000, 10};
    vecs[15] = '{16'h77FF, 16'h7FF0, 10};
    vecs[16] = '{16'h6801, 16'h0802, 7};

    // Reset state
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_wr",    {31'd0, write_mem}, 32'd0);
    chk("rst_addr",  {24'd0, data_address}, 32'd0);
    chk("rst_din",   {24'd0, data_in},   32'd0);
    chk("rst_rdmem", {31'd0, read_mem},  32'd1);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) convert(vecs[i].f, vecs[i].exp_val, vecs[i].exp_lat);

    // start re-pulsed during SHIFT must be ignored
    @(negedge clk);
    load_float(16'h3C00);
    wr_count  = 0;
    start     = 1'b1;
    @(posedge clk);
    #1 start  = 1'b0;
    rises     = 0;
    rise_edge = 0;
    done_prev = done;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done && !done_prev) begin
        rises     = rises + 1;
        rise_edge = k;
      end
      done_prev = done;
      start = (k == 3);
    end
    start = 1'b0;
    chk("repulse_rises",  rises,     32'd1);
    chk("repulse_edge",   rise_edge, 32'd16);
    chk("repulse_result", {16'd0, mem[5], mem[4]}, 32'h0001);
    chk("repulse_writes", wr_count,  32'd2);

    // Reset asserted while in WR_LO aborts without writing
    @(negedge clk);
    load_float(16'h5000);
    wr_count = 0;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("wrlo_we",   {31'd0, write_mem},    32'd1);
    chk("wrlo_addr", {24'd0, data_address}, 32'd4);
    reset = 1'b1;
    #1 chk("rst_gates_we", {31'd0, write_mem}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_lo",   {24'd0, mem[4]}, 32'hA5);
    chk("abort_hi",   {24'd0, mem[5]}, 32'h5A);
    chk("abort_done", {31'd0, done},   32'd0);
    repeat (25) @(posedge clk);
    #1;
    chk("abort_idle_done", {31'd0, done}, 32'd0);
    chk("abort_writes",    wr_count,      32'd0);

    convert(16'h3C00, 16'h0001, 16);
    convert(16'hC100, 16'hFFFE, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
